axi_lite_cmd_master: RTL and testbench
======================================

# axi_lite_cmd_master

AXI-Lite initiator that turns single-word commands from a simple valid/ready command port into AXI-Lite write or read transactions. It drives the `s3_axi_*` slave port of the adder/multiplier wrapper, or any AXI-Lite responder with the same channel widths. It returns one response per command: read data or write status. It also keeps a saturating count of error responses.

## Interface
- `DATA_WIDTH`, 32, data bus width in bits.
- `ADDR_WIDTH`, 8, address width in bits.
- `RESP_WIDTH`, 3, width of `bresp`/`rresp`.
- `m0_axi_aclk`  in  1  single clock; all logic is on the rising edge.
- `m0_axi_aresetn`  in  1  reset, synchronous, active-low.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  block can accept a command.
- `cmd_write`  in  1  1 = write, 0 = read.
- `cmd_addr`  in  ADDR_WIDTH  target address.
- `cmd_wdata`  in  DATA_WIDTH  write data; ignored on reads.
- `cmd_wstrb`  in  DATA_WIDTH/8+1  write strobes; ignored on reads.
- `rsp_valid`  out  1  response present.
- `rsp_ready`  in  1  consumer accepts the response.
- `rsp_write`  out  1  echo of `cmd_write` for this response.
- `rsp_data`  out  DATA_WIDTH  captured `rdata`; 0 for writes.
- `rsp_resp`  out  RESP_WIDTH  captured `bresp` or `rresp`.
- `err_count`  out  8  count of non-zero responses, saturating at 255.
- AXI-Lite master channels, directions as seen from this block:
  - `m0_axi_awaddr` out ADDR_WIDTH; `m0_axi_awvalid` out 1; `m0_axi_awready` in 1.
  - `m0_axi_wdata` out DATA_WIDTH; `m0_axi_wstrb` out DATA_WIDTH/8+1; `m0_axi_wvalid` out 1; `m0_axi_wready` in 1.
  - `m0_axi_bresp` in RESP_WIDTH; `m0_axi_bvalid` in 1; `m0_axi_bready` out 1.
  - `m0_axi_araddr` out ADDR_WIDTH; `m0_axi_arvalid` out 1; `m0_axi_arready` in 1.
  - `m0_axi_rdata` in DATA_WIDTH; `m0_axi_rresp` in RESP_WIDTH; `m0_axi_rvalid` in 1; `m0_axi_rready` out 1.

## Operation
- FSM states:
  - IDLE: `cmd_ready`=1.
  - WR_REQ: AW and W requests outstanding.
  - WR_RESP: `bready`=1.
  - RD_REQ: `arvalid`=1.
  - RD_DATA: `rready`=1.
  - RSP: `rsp_valid`=1.
- IDLE: when `cmd_valid`&`cmd_ready`, latch addr, wdata, wstrb and write.
  - Write → WR_REQ; read → RD_REQ.
- WR_REQ: `awvalid` and `wvalid` assert together on entry and are tracked independently.
  - Each deasserts on the cycle after its own handshake; AW and W may complete in either order or in the same cycle.
  - Leave for WR_RESP once both have completed.
  - AXI rule: once asserted, a valid and its payload stay stable until the handshake.
- WR_RESP: on `bvalid`&`bready`, capture `bresp`, set `rsp_data`=0, → RSP.
- RD_REQ: on `arready`, → RD_DATA.
- RD_DATA: on `rvalid`, capture `rdata` and `rresp`, → RSP.
- RSP: hold all `rsp_*` stable until `rsp_ready`, then → IDLE.
- `err_count` increments by 1 on each captured response with a non-zero resp value.
  - It holds at 255 and never wraps.
- Only one transaction is outstanding at a time; no pipelining across commands.

## Timing
- Reset (`m0_axi_aresetn`=0 at a clock edge):
  - State → IDLE.
  - All outputs 0, except `cmd_ready`, which reads 1 from the first cycle after reset.
  - `err_count`=0.
- Reset mid-transaction: abort immediately, drop all valids to 0, and discard any pending response.
  - The responder is reset by the same signal.
- All outputs are registered; there is no combinational path from any input to any output.
- Command accepted at edge N: AXI request valids are high in cycle N+1.
- Zero-wait responder:
  - Write: aw/w handshake at N+1, `bready` high N+2 with bvalid handshake, `rsp_valid` at N+3.
  - Read: ar handshake at N+1, r handshake at N+2, `rsp_valid` at N+3.
- `bready`/`rready` assert only in WR_RESP/RD_DATA.
  - `bvalid`/`rvalid` seen in any other state are ignored.
- Back-to-back: `cmd_ready` rises the cycle after `rsp_valid`&`rsp_ready`.
  - Minimum command-to-command spacing is 4 cycles.
- `rsp_ready` held low: the block stalls in RSP indefinitely with stable outputs and accepts no new command.

## Test plan
- Write to a zero-wait responder:
  - Stimulus: write addr 0x04, data 0x0000_0005, strb all ones.
  - Required: awaddr 0x04 and wdata 0x5 presented at N+1; `rsp_valid` at N+3 with `rsp_resp`=0, `rsp_write`=1.
- Read with delays:
  - Stimulus: read addr 0x08; responder holds arready low 3 cycles, then returns rdata 0x0000_000F after 2 more cycles.
  - Required: `arvalid`/`araddr` stable throughout the stall; `rsp_data`=0x0000_000F.
- Skewed write channels:
  - Stimulus: W accepted 2 cycles before AW.
  - Required: `wvalid` drops the cycle after its handshake; `awvalid` stays high; `bready` rises only after AW completes.
  - Repeat with AW before W.
- Error responses:
  - Stimulus: responder returns resp 2 on 300 consecutive reads.
  - Required: `err_count` reaches 255 and holds; `rsp_resp`=2 on each response.
- Response backpressure:
  - Stimulus: `rsp_ready` low for 5 cycles.
  - Required: `rsp_*` stable and `cmd_ready`=0 throughout; after release, a second command is accepted the following cycle.
- Reset mid-transaction:
  - Stimulus: assert reset while `awvalid`=1.
  - Required: all valids 0 and `err_count`=0 at the next edge; `cmd_ready`=1 the cycle after reset is released.

Source files
------------

// File: rtl/axi_lite_cmd_master.sv
// AXI-Lite initiator: converts single-word valid/ready commands into one AXI-Lite
// write or read at a time and returns one response per command, plus an error counter.
module axi_lite_cmd_master #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int RESP_WIDTH = 3
) (
  input  logic                      m0_axi_aclk,
  input  logic                      m0_axi_aresetn,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic                      cmd_write,
  input  logic [ADDR_WIDTH-1:0]     cmd_addr,
  input  logic [DATA_WIDTH-1:0]     cmd_wdata,
  input  logic [DATA_WIDTH/8:0]     cmd_wstrb,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic                      rsp_write,
  output logic [DATA_WIDTH-1:0]     rsp_data,
  output logic [RESP_WIDTH-1:0]     rsp_resp,
  output logic [7:0]                err_count,
  output logic [ADDR_WIDTH-1:0]     m0_axi_awaddr,
  output logic                      m0_axi_awvalid,
  input  logic                      m0_axi_awready,
  output logic [DATA_WIDTH-1:0]     m0_axi_wdata,
  output logic [DATA_WIDTH/8:0]     m0_axi_wstrb,
  output logic                      m0_axi_wvalid,
  input  logic                      m0_axi_wready,
  input  logic [RESP_WIDTH-1:0]     m0_axi_bresp,
  input  logic                      m0_axi_bvalid,
  output logic                      m0_axi_bready,
  output logic [ADDR_WIDTH-1:0]     m0_axi_araddr,
  output logic                      m0_axi_arvalid,
  input  logic                      m0_axi_arready,
  input  logic [DATA_WIDTH-1:0]     m0_axi_rdata,
  input  logic [RESP_WIDTH-1:0]     m0_axi_rresp,
  input  logic                      m0_axi_rvalid,
  output logic                      m0_axi_rready
);

  typedef enum logic [2:0] {
    S_IDLE, S_WR_REQ, S_WR_RESP, S_RD_REQ, S_RD_DATA, S_RSP
  } state_t;

  state_t                  r_state;
  state_t                  w_state_next;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic [DATA_WIDTH-1:0]   r_wdata;
  logic [DATA_WIDTH/8:0]   r_wstrb;
  logic                    r_write;
  logic                    r_awvalid;
  logic                    r_wvalid;
  logic [DATA_WIDTH-1:0]   r_rsp_data;
  logic [RESP_WIDTH-1:0]   r_rsp_resp;
  logic [7:0]              r_err_count;

  logic                    w_accept;
  logic                    w_awvalid_next;
  logic                    w_wvalid_next;
  logic                    w_capture;
  logic [DATA_WIDTH-1:0]   w_cap_data;
  logic [RESP_WIDTH-1:0]   w_cap_resp;
  logic                    w_err_inc;

  always_comb begin
    w_state_next   = r_state;
    w_accept       = 1'b0;
    w_awvalid_next = r_awvalid;
    w_wvalid_next  = r_wvalid;
    w_capture      = 1'b0;
    w_cap_data     = r_rsp_data;
    w_cap_resp     = r_rsp_resp;
    case (r_state)
      S_IDLE: begin
        if (cmd_valid) begin
          w_accept = 1'b1;
          if (cmd_write) begin
            w_state_next   = S_WR_REQ;
            w_awvalid_next = 1'b1;
            w_wvalid_next  = 1'b1;
          end else begin
            w_state_next = S_RD_REQ;
          end
        end
      end
      S_WR_REQ: begin
        // AW and W retire independently; move on once neither is still pending
        w_awvalid_next = r_awvalid & ~m0_axi_awready;
        w_wvalid_next  = r_wvalid & ~m0_axi_wready;
        if (!w_awvalid_next && !w_wvalid_next) begin
          w_state_next = S_WR_RESP;
        end
      end
      S_WR_RESP: begin
        if (m0_axi_bvalid) begin
          w_capture    = 1'b1;
          w_cap_data   = '0;
          w_cap_resp   = m0_axi_bresp;
          w_state_next = S_RSP;
        end
      end
      S_RD_REQ: begin
        if (m0_axi_arready) begin
          w_state_next = S_RD_DATA;
        end
      end
      S_RD_DATA: begin
        if (m0_axi_rvalid) begin
          w_capture    = 1'b1;
          w_cap_data   = m0_axi_rdata;
          w_cap_resp   = m0_axi_rresp;
          w_state_next = S_RSP;
        end
      end
      S_RSP: begin
        if (rsp_ready) begin
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  assign w_err_inc = w_capture && (w_cap_resp != '0) && (r_err_count != 8'hFF);

  always_ff @(posedge m0_axi_aclk) begin
    if (!m0_axi_aresetn) begin
      r_state     <= S_IDLE;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_wstrb     <= '0;
      r_write     <= 1'b0;
      r_awvalid   <= 1'b0;
      r_wvalid    <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_resp  <= '0;
      r_err_count <= '0;
    end else begin
      r_state   <= w_state_next;
      r_awvalid <= w_awvalid_next;
      r_wvalid  <= w_wvalid_next;
      if (w_accept) begin
        r_addr  <= cmd_addr;
        r_wdata <= cmd_wdata;
        r_wstrb <= cmd_wstrb;
        r_write <= cmd_write;
      end
      if (w_capture) begin
        r_rsp_data <= w_cap_data;
        r_rsp_resp <= w_cap_resp;
      end
      if (w_err_inc) begin
        r_err_count <= r_err_count + 8'd1;
      end
    end
  end

  // Every output is a register or a decode of the state register only
  assign cmd_ready      = (r_state == S_IDLE);
  assign rsp_valid      = (r_state == S_RSP);
  assign rsp_write      = r_write;
  assign rsp_data       = r_rsp_data;
  assign rsp_resp       = r_rsp_resp;
  assign err_count      = r_err_count;
  assign m0_axi_awaddr  = r_addr;
  assign m0_axi_awvalid = r_awvalid;
  assign m0_axi_wdata   = r_wdata;
  assign m0_axi_wstrb   = r_wstrb;
  assign m0_axi_wvalid  = r_wvalid;
  assign m0_axi_bready  = (r_state == S_WR_RESP);
  assign m0_axi_araddr  = r_addr;
  assign m0_axi_arvalid = (r_state == S_RD_REQ);
  assign m0_axi_rready  = (r_state == S_RD_DATA);

endmodule

// File: tb/tb_axi_lite_cmd_master.sv
// Directed plus randomized bench for axi_lite_cmd_master with a cycle-stepped
// AXI-Lite responder model and a transaction-level response/error-count model.
module tb_axi_lite_cmd_master;

  logic        clk;
  logic        aresetn;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [7:0]  cmd_addr;
  logic [31:0] cmd_wdata;
  logic [4:0]  cmd_wstrb;
  logic        rsp_valid, rsp_ready, rsp_write;
  logic [31:0] rsp_data;
  logic [2:0]  rsp_resp;
  logic [7:0]  err_count;
  logic [7:0]  awaddr, araddr;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [31:0] wdata, rdata;
  logic [4:0]  wstrb;
  logic [2:0]  bresp, rresp;

  axi_lite_cmd_master dut (
    .m0_axi_aclk(clk), .m0_axi_aresetn(aresetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_data(rsp_data), .rsp_resp(rsp_resp), .err_count(err_count),
    .m0_axi_awaddr(awaddr), .m0_axi_awvalid(awvalid), .m0_axi_awready(awready),
    .m0_axi_wdata(wdata), .m0_axi_wstrb(wstrb), .m0_axi_wvalid(wvalid), .m0_axi_wready(wready),
    .m0_axi_bresp(bresp), .m0_axi_bvalid(bvalid), .m0_axi_bready(bready),
    .m0_axi_araddr(araddr), .m0_axi_arvalid(arvalid), .m0_axi_arready(arready),
    .m0_axi_rdata(rdata), .m0_axi_rresp(rresp), .m0_axi_rvalid(rvalid), .m0_axi_rready(rready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int err_exp = 0;

  // Responder configuration and state
  int aw_dly = 0, w_dly = 0, ar_dly = 0, b_dly = 0, r_dly = 0;
  logic [2:0]  cfg_resp = 3'd0;
  logic [31:0] cfg_rdata = 32'd0;
  int aw_cnt = 0, w_cnt = 0, ar_cnt = 0, b_cnt = 0, r_cnt = 0;
  bit aw_got = 0, w_got = 0, ar_got = 0;
  logic [7:0]  seen_awaddr = 8'd0, seen_araddr = 8'd0;
  logic [31:0] seen_wdata = 32'd0;
  logic [4:0]  seen_wstrb = 5'd0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; update the responder from the handshakes of the cycle just ended
  task automatic tick();
    bit aw_hs, w_hs, ar_hs, b_hs, r_hs, rst, p_awv, p_wv, p_arv, p_hold;
    logic [7:0]  p_awaddr, p_araddr;
    logic [31:0] p_wdata, p_rdata;
    logic [4:0]  p_wstrb;
    logic [2:0]  p_resp;
    bit          p_write;
    aw_hs = awvalid && awready;  w_hs = wvalid && wready;  ar_hs = arvalid && arready;
    b_hs = bvalid && bready;     r_hs = rvalid && rready;
    p_awv = awvalid; p_awaddr = awaddr; p_wv = wvalid; p_wdata = wdata; p_wstrb = wstrb;
    p_arv = arvalid; p_araddr = araddr;
    p_hold = rsp_valid && !rsp_ready;
    p_write = rsp_write; p_rdata = rsp_data; p_resp = rsp_resp;
    rst = !aresetn;
    @(posedge clk); #1;
    cyc++;
    if (cyc > 50000) begin
      bad++;
      $fatal(1, "FAIL cycle_budget: observed=%0d expected<=50000", cyc);
    end
    if (rst) begin
      aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_cnt = 0; r_cnt = 0;
      aw_got = 0; w_got = 0; ar_got = 0;
    end else begin
      if (b_hs) begin aw_got = 0; w_got = 0; b_cnt = 0; end
      else if (aw_got && w_got) b_cnt++;
      if (r_hs) begin ar_got = 0; r_cnt = 0; end
      else if (ar_got) r_cnt++;
      if (aw_hs) begin aw_got = 1; seen_awaddr = p_awaddr; aw_cnt = 0; end
      else if (p_awv) aw_cnt++;
      if (w_hs) begin w_got = 1; seen_wdata = p_wdata; seen_wstrb = p_wstrb; w_cnt = 0; end
      else if (p_wv) w_cnt++;
      if (ar_hs) begin ar_got = 1; seen_araddr = p_araddr; ar_cnt = 0; end
      else if (p_arv) ar_cnt++;
      if (p_awv && !aw_hs) chk("aw_stable", {awvalid, awaddr}, {1'b1, p_awaddr});
      if (p_wv && !w_hs)   chk("w_stable", {wvalid, wdata, wstrb}, {1'b1, p_wdata, p_wstrb});
      if (p_arv && !ar_hs) chk("ar_stable", {arvalid, araddr}, {1'b1, p_araddr});
      if (p_hold) chk("rsp_stable", {rsp_valid, rsp_write, rsp_data, rsp_resp},
                      {1'b1, p_write, p_rdata, p_resp});
      if (bready && !(aw_got && w_got)) chk("bready_early", bready, 1'b0);
      if (rready && !ar_got) chk("rready_early", rready, 1'b0);
    end
    awready = awvalid && (aw_cnt >= aw_dly);
    wready  = wvalid && (w_cnt >= w_dly);
    arready = arvalid && (ar_cnt >= ar_dly);
    bvalid  = aw_got && w_got && (b_cnt >= b_dly);
    rvalid  = ar_got && (r_cnt >= r_dly);
    bresp   = bvalid ? cfg_resp : 3'd0;
    rresp   = rvalid ? cfg_resp : 3'd0;
    rdata   = rvalid ? cfg_rdata : 32'd0;
  endtask

  task automatic set_dly(input int aw, input int w, input int ar, input int b, input int r);
    aw_dly = aw; w_dly = w; ar_dly = ar; b_dly = b; r_dly = r;
  endtask

  task automatic send_cmd(input bit wr, input logic [7:0] a, input logic [31:0] d, input logic [4:0] s);
    int n = 0;
    while (!cmd_ready && n < 100) begin tick(); n++; end
    chk("cmd_ready_wait", cmd_ready, 1'b1);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
    tick();
    cmd_valid = 1'b0; cmd_write = $urandom_range(0, 1);
    cmd_addr = 8'($urandom); cmd_wdata = $urandom; cmd_wstrb = 5'($urandom);
  endtask

  task automatic wait_rsp();
    int n = 0;
    while (!rsp_valid && n < 200) begin tick(); n++; end
    chk("rsp_valid_wait", rsp_valid, 1'b1);
  endtask

  task automatic check_rsp(input bit wr, input logic [31:0] ed, input logic [2:0] er,
                           input logic [7:0] a, input logic [31:0] d, input logic [4:0] s);
    chk("rsp_write", rsp_write, wr);
    chk("rsp_data", rsp_data, ed);
    chk("rsp_resp", rsp_resp, er);
    if (er != 3'd0 && err_exp < 255) err_exp++;
    chk("err_count", err_count, err_exp[7:0]);
    chk("cmd_ready_busy", cmd_ready, 1'b0);
    if (wr) begin
      chk("seen_awaddr", seen_awaddr, a);
      chk("seen_wdata", seen_wdata, d);
      chk("seen_wstrb", seen_wstrb, s);
    end else begin
      chk("seen_araddr", seen_araddr, a);
    end
  endtask

  task automatic pop_rsp();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("rsp_drop", rsp_valid, 1'b0);
    chk("cmd_ready_back", cmd_ready, 1'b1);
  endtask

  task automatic transact(input bit wr, input logic [7:0] a, input logic [31:0] d,
                          input logic [4:0] s, input int hold);
    send_cmd(wr, a, d, s);
    wait_rsp();
    repeat (hold) tick();
    check_rsp(wr, wr ? 32'd0 : cfg_rdata, cfg_resp, a, d, s);
    pop_rsp();
  endtask

  initial begin
    bit          wr;
    logic [7:0]  a;
    logic [31:0] d;
    logic [4:0]  s;
    aresetn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    cmd_wstrb = '0; rsp_ready = 1'b0;
    awready = 0; wready = 0; arready = 0; bvalid = 0; rvalid = 0;
    bresp = '0; rresp = '0; rdata = '0;

    // Reset state
    tick(); tick();
    chk("reset_ctrl", {awvalid, wvalid, arvalid, bready, rready, rsp_valid, rsp_write, rsp_resp, err_count}, '0);
    chk("reset_data", {awaddr, araddr, wdata, wstrb}, '0);
    chk("reset_rsp_data", rsp_data, '0);
    aresetn = 1'b1;
    tick();
    chk("reset_cmd_ready", cmd_ready, 1'b1);

    // Zero-wait write: exact latency
    set_dly(0, 0, 0, 0, 0); cfg_resp = 3'd0;
    send_cmd(1'b1, 8'h04, 32'h0000_0005, 5'h1F);
    chk("wr_req_n1", {awvalid, awaddr, wvalid, wdata, wstrb}, {1'b1, 8'h04, 1'b1, 32'h5, 5'h1F});
    tick();
    chk("wr_bready_n2", {bready, bvalid, awvalid, wvalid}, 4'b1100);
    tick();
    chk("wr_rsp_n3", rsp_valid, 1'b1);
    check_rsp(1'b1, 32'd0, 3'd0, 8'h04, 32'h5, 5'h1F);
    pop_rsp();

    // Zero-wait read: exact latency
    cfg_rdata = 32'hCAFE_0123;
    send_cmd(1'b0, 8'h0C, 32'h0, 5'h0);
    chk("rd_req_n1", {arvalid, araddr}, {1'b1, 8'h0C});
    tick();
    chk("rd_rready_n2", {rready, arvalid}, 2'b10);
    tick();
    chk("rd_rsp_n3", rsp_valid, 1'b1);
    check_rsp(1'b0, 32'hCAFE_0123, 3'd0, 8'h0C, 32'h0, 5'h0);
    pop_rsp();

    // Read with arready stalled 3 cycles, data 2 cycles later
    set_dly(0, 0, 3, 0, 2); cfg_rdata = 32'h0000_000F;
    send_cmd(1'b0, 8'h08, 32'h0, 5'h0);
    for (int i = 0; i < 3; i++) begin
      chk("ar_stall", {arvalid, araddr, arready, rready}, {1'b1, 8'h08, 1'b0, 1'b0});
      tick();
    end
    chk("ar_release", {arvalid, arready}, 2'b11);
    wait_rsp();
    check_rsp(1'b0, 32'h0000_000F, 3'd0, 8'h08, 32'h0, 5'h0);
    pop_rsp();

    // W accepted two cycles before AW
    set_dly(2, 0, 0, 0, 0);
    send_cmd(1'b1, 8'h20, 32'h1234_5678, 5'h03);
    tick();
    for (int i = 0; i < 2; i++) begin
      chk("skew_w_first", {wvalid, awvalid, bready}, 3'b010);
      tick();
    end
    chk("skew_w_done", {wvalid, awvalid, bready}, 3'b001);
    wait_rsp();
    check_rsp(1'b1, 32'd0, 3'd0, 8'h20, 32'h1234_5678, 5'h03);
    pop_rsp();

    // AW accepted two cycles before W
    set_dly(0, 2, 0, 0, 0);
    send_cmd(1'b1, 8'h24, 32'h8765_4321, 5'h1C);
    tick();
    for (int i = 0; i < 2; i++) begin
      chk("skew_aw_first", {wvalid, awvalid, bready}, 3'b100);
      tick();
    end
    chk("skew_aw_done", {wvalid, awvalid, bready}, 3'b001);
    wait_rsp();
    check_rsp(1'b1, 32'd0, 3'd0, 8'h24, 32'h8765_4321, 5'h1C);
    pop_rsp();

    // Response backpressure, then immediate next command
    set_dly(0, 0, 0, 1, 0); cfg_resp = 3'd1;
    send_cmd(1'b1, 8'h10, 32'hA5A5_5A5A, 5'h11);
    wait_rsp();
    check_rsp(1'b1, 32'd0, 3'd1, 8'h10, 32'hA5A5_5A5A, 5'h11);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_stall", {rsp_valid, cmd_ready, rsp_resp}, {1'b1, 1'b0, 3'd1});
    end
    rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
    chk("bp_cmd_ready", cmd_ready, 1'b1);
    cfg_resp = 3'd0; cfg_rdata = 32'h0BAD_F00D; set_dly(0, 0, 0, 0, 0);
    send_cmd(1'b0, 8'h30, 32'h0, 5'h0);
    chk("bp_next_accept", {arvalid, araddr}, {1'b1, 8'h30});
    wait_rsp();
    check_rsp(1'b0, 32'h0BAD_F00D, 3'd0, 8'h30, 32'h0, 5'h0);
    pop_rsp();

    // Randomized traffic
    for (int k = 0; k < 60; k++) begin
      set_dly($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
              $urandom_range(0, 3), $urandom_range(0, 3));
      cfg_resp = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
      cfg_rdata = $urandom;
      wr = 1'($urandom_range(0, 1)); a = 8'($urandom); d = $urandom; s = 5'($urandom);
      transact(wr, a, d, s, $urandom_range(0, 3));
    end

    // Error counter saturation
    set_dly(0, 0, 0, 0, 0); cfg_resp = 3'd2;
    for (int k = 0; k < 300; k++) begin
      cfg_rdata = $urandom;
      transact(1'b0, 8'($urandom), 32'h0, 5'h0, 0);
    end
    chk("err_saturated", err_count, 8'd255);

    // Reset while awvalid is high
    set_dly(10, 10, 0, 0, 0); cfg_resp = 3'd0;
    send_cmd(1'b1, 8'h40, 32'hDEAD_BEEF, 5'h1F);
    chk("mid_awvalid", awvalid, 1'b1);
    tick();
    aresetn = 1'b0;
    tick();
    chk("mid_reset_valids", {awvalid, wvalid, arvalid, bready, rready, rsp_valid}, 6'b0);
    chk("mid_reset_err", err_count, 8'd0);
    err_exp = 0;
    aresetn = 1'b1;
    tick();
    chk("mid_reset_ready", cmd_ready, 1'b1);
    set_dly(0, 0, 0, 0, 0); cfg_rdata = 32'h5555_AAAA;
    transact(1'b0, 8'h44, 32'h0, 5'h0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
